// File: rtl/vcpu_pkg.sv
// vcpu_pkg: shared defaults, vector type and clear-FSM states for the
// vector register file.
package vcpu_pkg;
    localparam int VRF_LANES  = 6;
    localparam int VRF_EW     = 8;
    localparam int VRF_NREGS  = 15;
    localparam int SCALAR_REG = 0;

    typedef logic [VRF_LANES*VRF_EW-1:0] vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;
endpackage

// File: rtl/vrf_scoreboard.sv
// vrf_scoreboard: per-register busy bits for the issue stage.
// Write-clear, issue-set (set beats write-clear) and sweep-clear (sweep beats set).
// Optional macro VRF_BYPASS_EN: busy outputs also drop for a clear arriving this cycle.
module vrf_scoreboard #(
    parameter int NREGS = 15,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_idx,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_idx,
    input  logic          i_swp_en,
    input  logic [AW-1:0] i_swp_idx,
    input  logic [AW-1:0] i_rd1_idx,
    input  logic [AW-1:0] i_rd2_idx,
    output logic          o_rd1_busy,
    output logic          o_rd2_busy
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [NREGS-1:0] w_busy_view;

    // Next busy vector with the set/clear priority applied in order.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if (i_clr_en && i_clr_idx == AW'(i)) w_busy_nxt[i] = 1'b0;
            if (i_set_en && i_set_idx == AW'(i)) w_busy_nxt[i] = 1'b1;
            if (i_swp_en && i_swp_idx == AW'(i)) w_busy_nxt[i] = 1'b0;
        end
    end

    // Busy view seen by the read ports.
    always_comb begin
        w_busy_view = r_busy;
`ifdef VRF_BYPASS_EN
        for (int i = 0; i < NREGS; i++) begin
            if ((i_clr_en && i_clr_idx == AW'(i)) || (i_swp_en && i_swp_idx == AW'(i)))
                w_busy_view[i] = 1'b0;
        end
`endif
    end

    // Read-port lookup; indices past the last register report not busy.
    always_comb begin
        o_rd1_busy = 1'b0;
        o_rd2_busy = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (i_rd1_idx == AW'(i)) o_rd1_busy = w_busy_view[i];
            if (i_rd2_idx == AW'(i)) o_rd2_busy = w_busy_view[i];
        end
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end
endmodule

// File: rtl/vregfile_sb.sv
// vregfile_sb: NREGS x LANES x EW vector register file, register 0 is the
// scalar bank. Two combinational read ports, masked main write, full-vector
// address-register write, busy scoreboard and a one-register-per-cycle clear sweep.
// Optional macro VRF_BYPASS_EN: read ports forward same-cycle writes.
module vregfile_sb
    import vcpu_pkg::*;
#(
    parameter int LANES = VRF_LANES,
    parameter int EW    = VRF_EW,
    parameter int NREGS = VRF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       rd1_addr,
    input  logic [AW-1:0]       rd2_addr,
    input  logic                rd2_scalar,
    output logic [LANES*EW-1:0] rd1_data,
    output logic [LANES*EW-1:0] rd2_data,
    output logic                rd1_busy,
    output logic                rd2_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [LANES*EW-1:0] wr_data,
    input  logic [LANES-1:0]    wr_mask,
    input  logic                wr_scalar,
    input  logic                sp_we,
    input  logic [AW-1:0]       sp_addr,
    input  logic [LANES*EW-1:0] sp_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_dst,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                wr_drop
);
    localparam int VW = LANES * EW;

    logic [VW-1:0] r_rf [NREGS];
    logic [VW-1:0] w_rf_wr [NREGS];
    clr_state_t    r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic          r_drop;
    logic          w_sweep, w_vec_ok, w_sca_ok, w_sp_ok, w_drop_nxt;
    logic [AW-1:0] w_rd2_idx, w_clr_idx;

    assign w_sweep   = (r_state == SWEEP);
    assign w_vec_ok  = wr_en & ~wr_scalar & ~w_sweep & (int'(wr_addr) < NREGS);
    assign w_sca_ok  = wr_en &  wr_scalar & ~w_sweep & (int'(wr_addr) < LANES);
    assign w_sp_ok   = sp_we & ~w_sweep & (int'(sp_addr) < NREGS);
    assign w_drop_nxt = (wr_en & ~(w_vec_ok | w_sca_ok)) | (sp_we & ~w_sp_ok);
    assign w_rd2_idx = rd2_scalar ? AW'(SCALAR_REG) : rd2_addr;
    assign w_clr_idx = wr_scalar ? AW'(SCALAR_REG) : wr_addr;
    assign clr_busy  = w_sweep;
    assign wr_drop   = r_drop;

    // Write merge: sp_data fills the register, main write overrides its enabled lanes.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            w_rf_wr[r] = r_rf[r];
            if (w_sp_ok && sp_addr == AW'(r)) w_rf_wr[r] = sp_data;
            for (int l = 0; l < LANES; l++) begin
                if (w_vec_ok && wr_addr == AW'(r) && wr_mask[l])
                    w_rf_wr[r][l*EW +: EW] = wr_data[l*EW +: EW];
                if (w_sca_ok && r == SCALAR_REG && wr_addr == AW'(l))
                    w_rf_wr[r][l*EW +: EW] = wr_data[EW-1:0];
            end
        end
    end

    // Read ports; out-of-range indices return zero.
    always_comb begin
        rd1_data = '0;
        rd2_data = '0;
        for (int r = 0; r < NREGS; r++) begin
`ifdef VRF_BYPASS_EN
            if (rd1_addr  == AW'(r)) rd1_data = w_rf_wr[r];
            if (w_rd2_idx == AW'(r)) rd2_data = w_rf_wr[r];
`else
            if (rd1_addr  == AW'(r)) rd1_data = r_rf[r];
            if (w_rd2_idx == AW'(r)) rd2_data = r_rf[r];
`endif
        end
    end

    // Clear-sweep next state: walk ptr over every register once, then idle.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                if (r_ptr == AW'(NREGS - 1)) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + AW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, sweep pointer and registered drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Storage: the swept register is zeroed, all others take the merged write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) r_rf[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_sweep && r_ptr == AW'(r)) r_rf[r] <= '0;
                else                            r_rf[r] <= w_rf_wr[r];
            end
        end
    end

    vrf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (iss_valid),
        .i_set_idx  (iss_dst),
        .i_clr_en   (w_vec_ok | w_sca_ok),
        .i_clr_idx  (w_clr_idx),
        .i_swp_en   (w_sweep),
        .i_swp_idx  (r_ptr),
        .i_rd1_idx  (rd1_addr),
        .i_rd2_idx  (w_rd2_idx),
        .o_rd1_busy (rd1_busy),
        .o_rd2_busy (rd2_busy)
    );
endmodule

// File: doc/vregfile_sb.md
# vregfile_sb

Parametrised vector register file for the vector CPU. It holds `NREGS` vectors of `LANES` × `EW`-bit elements, and register 0 is the scalar bank, one scalar per lane. It provides two read ports, one masked main write port, a secondary address-register write port, a per-register busy scoreboard for the issue stage and a sequential clear sweep. It sits between decode/issue and the vector ALU and supersedes the fixed 15×6×8 register file.

## Interface
Parameters:
- `LANES`, 6, elements per vector.
- `EW`, 8, element width in bits.
- `NREGS`, 15, number of vector registers; register 0 is the scalar bank.
- `AW`, `$clog2(NREGS)`, register index width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `rd1_addr` in AW: read port 1 index.
- `rd2_addr` in AW: read port 2 index.
- `rd2_scalar` in 1: port 2 returns register 0 instead of `rd2_addr`.
- `rd1_data` out LANES×EW: read data, port 1.
- `rd2_data` out LANES×EW: read data, port 2.
- `rd1_busy` out 1: scoreboard bit of the effective port 1 register.
- `rd2_busy` out 1: scoreboard bit of the effective port 2 register.
- `wr_en` in 1: main write strobe.
- `wr_addr` in AW: destination register; in scalar mode, the lane index.
- `wr_data` in LANES×EW: write data.
- `wr_mask` in LANES: per-lane write enable, vector mode only.
- `wr_scalar` in 1: scalar write, `wr_data[0]` goes to `rf[0][wr_addr]`.
- `sp_we` in 1: address-register write strobe.
- `sp_addr` in AW: address-register index.
- `sp_data` in LANES×EW: address-register data.
- `iss_valid` in 1: instruction issued.
- `iss_dst` in AW: register the issued instruction will write.
- `clr_req` in 1: start a clear sweep.
- `clr_busy` out 1: sweep in progress.
- `wr_drop` out 1: one-cycle pulse when a write was discarded.

## Operation
- Reads are combinational: `rd1_data = rf[rd1_addr]`; `rd2_data = rd2_scalar ? rf[0] : rf[rd2_addr]`. An index ≥ NREGS reads as all zeros and not busy.
- Vector write (`wr_en & !wr_scalar`): lane i of `rf[wr_addr]` is updated iff `wr_mask[i]`. A zero mask is legal and changes nothing, but still clears the busy bit.
- Scalar write (`wr_en & wr_scalar`): only `rf[0][wr_addr]` changes; `wr_mask` is ignored. `wr_addr` ≥ LANES counts as a dropped write.
- `sp_we` writes the full vector `rf[sp_addr]`. If it hits the same register as the main write in the same cycle, the main write wins lanes it enables and `sp_data` fills the rest.
- Any write with an index ≥ NREGS is discarded and pulses `wr_drop`.
- Scoreboard: `iss_valid` sets `busy[iss_dst]`; a main write clears `busy[wr_addr]` (scalar writes clear `busy[0]`); `sp_we` never touches busy. If set and clear hit the same register in one cycle, set wins.
- Clear FSM has two states, IDLE and SWEEP.
  - IDLE→SWEEP on `clr_req`; `ptr` = 0.
  - In SWEEP each cycle: `rf[ptr]` ← 0, `busy[ptr]` ← 0, `ptr++`. After `ptr` = NREGS−1 the FSM returns to IDLE.
  - `clr_req` while in SWEEP is ignored.
  - During SWEEP, `wr_en`/`sp_we` are discarded with `wr_drop`. `iss_valid` is still accepted, but a set on the register being swept that cycle is lost, because clear wins.
- Reset: all `rf` = 0, all busy = 0, IDLE, `ptr` = 0, `clr_busy` = 0, `wr_drop` = 0.

## Timing
- Read latency 0; a write is visible on the read ports the cycle after the strobe (without bypass).
- A busy set or clear is visible on `rd*_busy` the cycle after.
- `clr_busy` rises the cycle after `clr_req` and stays high for exactly NREGS cycles.
- `wr_drop` is registered: it is high the cycle after the offending strobe.
- Reset asserted mid-sweep aborts the sweep immediately; contents are zero regardless.

## Configuration
- `VRF_BYPASS_EN` defined: read ports forward the same-cycle main write, merged per `wr_mask` (or the scalar lane), plus `sp_data` per the priority above. Read-after-write then has zero-cycle latency. `rd*_busy` also reports 0 for a register whose clear arrives that cycle.
- `VRF_BYPASS_EN` undefined: reads see register state only.

## Structure
- Shared package `vcpu_pkg`: default `LANES`/`EW`/`NREGS`, `vec_t` typedef (packed LANES×EW), `clr_state_t` enum {IDLE, SWEEP}, scalar register index constant 0.
- One sub-module, `vrf_scoreboard`: busy vector, set/clear priority and sweep clear. The storage, write merge and FSM stay in the top module.

## Test plan
- After reset, read all registers → zero data, busy 0, `clr_busy` 0.
- Vector write r3 = 0x0605_0403_0201 with mask 0b001111, then read r3 → 0x0000_0403_0201.
- Scalar write lane 2 = 0xAB, then read r0 with `rd2_scalar`=1 → only lane 2 = 0xAB. Scalar write lane 7 → `wr_drop`=1 next cycle, r0 unchanged.
- Issue `iss_dst`=5; next cycle `rd1_addr`=5 → busy 1. Write r5 in the same cycle as `iss_valid` for r5 → busy stays 1.
- Same-cycle main write to r4 (mask 0b000011, 0x11 in each lane) and `sp_we` to r4 (0xFF in each lane) → r4 = FF FF FF FF 11 11.
- Fill all registers, pulse `clr_req` → `clr_busy` high 15 cycles, a write during the sweep drops, all registers end at 0. Repeat with `rst_n` asserted at sweep cycle 4.
